// File: rtl/sprite_blit_ctrl.sv
// Blit sequencer: copies a w x h source rectangle into the 240x160 framebuffer with colour-key and clipping.
// Source address leads the framebuffer write by two cycles to cover the registered source read.
module sprite_blit_ctrl #(
  parameter int          FB_W = 240,
  parameter int          FB_H = 160,
  parameter int          AW   = 19,
  parameter logic [23:0] KEY  = 24'hFF00FF
) (
  input  logic          Clk,
  input  logic          Reset_h,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_src,
  input  logic [AW-1:0] req_src_base,
  input  logic [9:0]    req_src_stride,
  input  logic [8:0]    req_w,
  input  logic [7:0]    req_h,
  input  logic [8:0]    req_dst_x,
  input  logic [7:0]    req_dst_y,
  input  logic          req_key_en,
  output logic          src_sel,
  output logic [AW-1:0] src_read_address,
  input  logic [23:0]   src_data,
  output logic [AW-1:0] fb_write_address,
  output logic [23:0]   fb_data_In,
  output logic          fb_we,
  output logic          busy,
  output logic          done
);

  localparam logic [9:0]    FB_W10 = 10'(FB_W);
  localparam logic [9:0]    FB_H10 = 10'(FB_H);
  localparam logic [AW-1:0] FB_W_A = AW'(FB_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic          accept, zero_size, last_col, last_row, pix_write;
  logic [8:0]    w_q, col, dst_x_q;
  logic [7:0]    h_q, row;
  logic [9:0]    stride_q;
  logic          key_en_q;
  logic [AW-1:0] src_row_base, fb_row_base, fb_addr;
  logic [AW-1:0] y_a, row0;
  logic [9:0]    abs_x, abs_y;

  // Stage 1: metadata for the pixel whose source data is on src_data this cycle.
  logic          s1_vld, s1_clip;
  logic [AW-1:0] s1_addr;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign zero_size = (req_w == 9'd0) || (req_h == 8'd0);
  assign last_col  = (col == w_q - 9'd1);
  assign last_row  = (row == h_q - 8'd1);

  // Row start y*240 formed as y*256 - y*16, keeping multipliers off the accept path.
  assign y_a  = AW'(req_dst_y);
  assign row0 = (y_a << 8) - (y_a << 4);

  assign pix_write = s1_vld && !s1_clip && !(key_en_q && (src_data == KEY));

  always_ff @(posedge Clk) begin
    if (Reset_h) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !zero_size) state_nxt = RUN;
      RUN:     if (last_col && last_row) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      done             <= 1'b0;
      fb_we            <= 1'b0;
      fb_write_address <= '0;
      fb_data_In       <= '0;
      src_read_address <= '0;
      src_sel          <= 1'b0;
      s1_vld           <= 1'b0;
      s1_clip          <= 1'b0;
      s1_addr          <= '0;
      w_q              <= '0;
      h_q              <= '0;
      stride_q         <= '0;
      dst_x_q          <= '0;
      key_en_q         <= 1'b0;
      col              <= '0;
      row              <= '0;
      src_row_base     <= '0;
      fb_row_base      <= '0;
      fb_addr          <= '0;
      abs_x            <= '0;
      abs_y            <= '0;
    end else begin
      done   <= 1'b0;
      fb_we  <= 1'b0;
      s1_vld <= 1'b0;

      if (accept) begin
        w_q              <= req_w;
        h_q              <= req_h;
        stride_q         <= req_src_stride;
        dst_x_q          <= req_dst_x;
        key_en_q         <= req_key_en;
        src_sel          <= req_src;
        src_read_address <= req_src_base;
        src_row_base     <= req_src_base;
        col              <= '0;
        row              <= '0;
        abs_x            <= {1'b0, req_dst_x};
        abs_y            <= {2'b00, req_dst_y};
        fb_row_base      <= row0;
        fb_addr          <= row0 + AW'(req_dst_x);
        if (zero_size) done <= 1'b1;
      end

      if (state == RUN) begin
        s1_vld  <= 1'b1;
        s1_addr <= fb_addr;
        s1_clip <= (abs_x >= FB_W10) || (abs_y >= FB_H10);
        if (last_col) begin
          col              <= '0;
          row              <= row + 8'd1;
          src_row_base     <= src_row_base + AW'(stride_q);
          src_read_address <= src_row_base + AW'(stride_q);
          fb_row_base      <= fb_row_base + FB_W_A;
          fb_addr          <= fb_row_base + FB_W_A + AW'(dst_x_q);
          abs_x            <= {1'b0, dst_x_q};
          abs_y            <= abs_y + 10'd1;
        end else begin
          col              <= col + 9'd1;
          src_read_address <= src_read_address + AW'(1);
          fb_addr          <= fb_addr + AW'(1);
          abs_x            <= abs_x + 10'd1;
        end
      end

      if (state == DONE) done <= 1'b1;

      // Suppressed slots leave address/data untouched; only fb_we marks a real write.
      if (pix_write) begin
        fb_we            <= 1'b1;
        fb_write_address <= s1_addr;
        fb_data_In       <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Randomised and directed bench for sprite_blit_ctrl against a per-cycle expected timeline.
module tb_sprite_blit_ctrl;

  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int TL = 1024;

  logic        Clk = 1'b0;
  logic        Reset_h = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_src = 1'b0;
  logic [18:0] req_src_base = '0;
  logic [9:0]  req_src_stride = '0;
  logic [8:0]  req_w = '0;
  logic [7:0]  req_h = '0;
  logic [8:0]  req_dst_x = '0;
  logic [7:0]  req_dst_y = '0;
  logic        req_key_en = 1'b0;
  logic        src_sel;
  logic [18:0] src_read_address;
  logic [23:0] src_data = '0;
  logic [18:0] fb_write_address;
  logic [23:0] fb_data_In;
  logic        fb_we, busy, done;

  typedef struct {
    logic        src;
    logic [18:0] base;
    logic [9:0]  stride;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [8:0]  dx;
    logic [7:0]  dy;
    logic        ken;
  } cmd_t;

  int n_pass = 0;
  int n_total = 0;
  int key_addr = -1;
  int key_mod = 0;
  logic [23:0] salt = '0;

  bit          e_we [TL];
  logic [18:0] e_fa [TL];
  logic [23:0] e_fd [TL];
  bit          e_sv [TL];
  logic [18:0] e_sa [TL];
  bit          e_done [TL];
  bit          e_busy [TL];
  bit          e_selv [TL];
  bit          e_sel [TL];

  sprite_blit_ctrl dut (
    .Clk(Clk), .Reset_h(Reset_h), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_src_base(req_src_base), .req_src_stride(req_src_stride),
    .req_w(req_w), .req_h(req_h), .req_dst_x(req_dst_x), .req_dst_y(req_dst_y),
    .req_key_en(req_key_en), .src_sel(src_sel), .src_read_address(src_read_address),
    .src_data(src_data), .fb_write_address(fb_write_address), .fb_data_In(fb_data_In),
    .fb_we(fb_we), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] pix(input logic [18:0] a);
    if (key_addr >= 0 && int'(a) == key_addr) return KEY;
    if (key_mod != 0 && (int'(a) % key_mod) == 0) return KEY;
    return {5'b0, a} ^ salt;
  endfunction

  // Source RAM with a 1-cycle registered read.
  always @(posedge Clk) src_data <= pix(src_read_address);

  function automatic cmd_t mk(input logic src, input int base, input int stride, input int w,
                              input int h, input int dx, input int dy, input logic ken);
    cmd_t c;
    c.src = src; c.base = 19'(base); c.stride = 10'(stride); c.w = 9'(w); c.h = 8'(h);
    c.dx = 9'(dx); c.dy = 8'(dy); c.ken = ken;
    return c;
  endfunction

  task automatic clear_tl();
    for (int i = 0; i < TL; i++) begin
      e_we[i] = 0; e_fa[i] = '0; e_fd[i] = '0; e_sv[i] = 0; e_sa[i] = '0;
      e_done[i] = 0; e_busy[i] = 0; e_selv[i] = 0; e_sel[i] = 0;
    end
  endtask

  // Reference: plain raster walk with multiplies, placed on a timeline from accept edge t0.
  task automatic model(input cmd_t c, input int t0, output int tdone);
    int n, k, a, x, y;
    logic [23:0] d;
    n = int'(c.w) * int'(c.h);
    if (n == 0) begin
      tdone = t0 + 1;
    end else begin
      for (int r = 0; r < int'(c.h); r++) begin
        for (int cl = 0; cl < int'(c.w); cl++) begin
          k = r * int'(c.w) + cl;
          a = (int'(c.base) + r * int'(c.stride) + cl) % (1 << 19);
          e_sv[t0 + 1 + k] = 1;
          e_sa[t0 + 1 + k] = 19'(a);
          x = int'(c.dx) + cl;
          y = int'(c.dy) + r;
          d = pix(19'(a));
          if (x < 240 && y < 160 && !(c.ken && d == KEY)) begin
            e_we[t0 + 3 + k] = 1;
            e_fa[t0 + 3 + k] = 19'(y * 240 + x);
            e_fd[t0 + 3 + k] = d;
          end
        end
      end
      for (int t = t0 + 1; t <= t0 + 2 + n; t++) e_busy[t] = 1;
      tdone = t0 + 3 + n;
    end
    for (int t = t0 + 1; t <= tdone; t++) begin
      e_selv[t] = 1;
      e_sel[t] = c.src;
    end
    e_done[tdone] = 1;
  endtask

  task automatic drive(input cmd_t c);
    req_src = c.src; req_src_base = c.base; req_src_stride = c.stride;
    req_w = c.w; req_h = c.h; req_dst_x = c.dx; req_dst_y = c.dy; req_key_en = c.ken;
  endtask

  // Runs one command, or two with the second held valid from the cycle after the first accept.
  task automatic run_cmds(input string nm, input cmd_t a, input cmd_t b, input bit two);
    int tda, tdb, tend;
    clear_tl();
    model(a, 0, tda);
    tdb = tda;
    if (two) model(b, tda, tdb);
    tend = tdb + 2;
    @(negedge Clk);
    drive(a);
    req_valid = 1'b1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle got=%b exp=1", nm, req_ready);
    else n_pass++;
    @(posedge Clk);
    for (int cyc = 1; cyc <= tend; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin
        if (two) drive(b);
        else req_valid = 1'b0;
      end
      if (two && cyc == tda + 1) req_valid = 1'b0;
      n_total++;
      if (fb_we !== e_we[cyc]) $display("FAIL %s fb_we cyc=%0d got=%b exp=%b", nm, cyc, fb_we, e_we[cyc]);
      else n_pass++;
      n_total++;
      if (done !== e_done[cyc]) $display("FAIL %s done cyc=%0d got=%b exp=%b", nm, cyc, done, e_done[cyc]);
      else n_pass++;
      n_total++;
      if (busy !== e_busy[cyc] || req_ready !== !e_busy[cyc])
        $display("FAIL %s busy/ready cyc=%0d got=%b/%b exp=%b/%b", nm, cyc, busy, req_ready,
                 e_busy[cyc], !e_busy[cyc]);
      else n_pass++;
      if (e_we[cyc]) begin
        n_total++;
        if (fb_write_address !== e_fa[cyc] || fb_data_In !== e_fd[cyc])
          $display("FAIL %s fb_write cyc=%0d got=%0d/%h exp=%0d/%h", nm, cyc, fb_write_address,
                   fb_data_In, e_fa[cyc], e_fd[cyc]);
        else n_pass++;
      end
      if (e_sv[cyc]) begin
        n_total++;
        if (src_read_address !== e_sa[cyc])
          $display("FAIL %s src_addr cyc=%0d got=%0d exp=%0d", nm, cyc, src_read_address, e_sa[cyc]);
        else n_pass++;
      end
      if (e_selv[cyc]) begin
        n_total++;
        if (src_sel !== e_sel[cyc]) $display("FAIL %s src_sel cyc=%0d got=%b exp=%b", nm, cyc, src_sel, e_sel[cyc]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    Reset_h = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0)
      $display("FAIL reset_ctrl got=%b%b%b%b exp=1000", req_ready, busy, done, fb_we);
    else n_pass++;
    n_total++;
    if (src_read_address !== '0 || fb_write_address !== '0 || fb_data_In !== '0 || src_sel !== 1'b0)
      $display("FAIL reset_data got=%0d/%0d/%h/%b exp=0/0/0/0", src_read_address, fb_write_address,
               fb_data_In, src_sel);
    else n_pass++;
    Reset_h = 1'b0;
  endtask

  task automatic test_basic();
    cmd_t c;
    key_addr = -1; key_mod = 0; salt = '0;
    c = mk(1'b0, 0, 4, 2, 2, 0, 0, 1'b0);
    run_cmds("basic", c, c, 1'b0);
    key_addr = 1;
    c.ken = 1'b1;
    run_cmds("keyed", c, c, 1'b0);
    key_addr = -1;
  endtask

  task automatic test_clip();
    cmd_t c;
    c = mk(1'b1, 100, 3, 3, 1, 239, 159, 1'b0);
    run_cmds("clip_corner", c, c, 1'b0);
  endtask

  task automatic test_zero();
    cmd_t c;
    c = mk(1'b1, 77, 8, 0, 5, 3, 3, 1'b0);
    run_cmds("zero_w", c, c, 1'b0);
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    c = mk(1'b0, 16, 4, 4, 4, 2, 2, 1'b0);
    @(negedge Clk);
    drive(c);
    req_valid = 1'b1;
    @(posedge Clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) req_valid = 1'b0;
      if (cyc == 4) Reset_h = 1'b1;
      if (cyc >= 5) begin
        n_total++;
        if (fb_we !== 1'b0 || done !== 1'b0)
          $display("FAIL reset_mid quiet cyc=%0d got we=%b done=%b exp=0/0", cyc, fb_we, done);
        else n_pass++;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_mid ready cyc=%0d got=%b exp=1", cyc, req_ready);
        else n_pass++;
      end
      if (cyc == 5) Reset_h = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    cmd_t a, b;
    salt = 24'h123400;
    a = mk(1'b0, 40, 20, 3, 2, 10, 5, 1'b0);
    b = mk(1'b1, 500, 7, 2, 1, 100, 50, 1'b0);
    run_cmds("b2b", a, b, 1'b1);
    a = mk(1'b1, 9, 1, 0, 0, 0, 0, 1'b0);
    b = mk(1'b0, 60, 5, 2, 2, 238, 158, 1'b0);
    run_cmds("b2b_zero", a, b, 1'b1);
  endtask

  task automatic test_random();
    cmd_t a, b;
    for (int it = 0; it < 16; it++) begin
      salt = 24'($urandom);
      key_mod = $urandom_range(0, 5);
      key_addr = -1;
      a.src = 1'($urandom);
      a.base = ($urandom_range(0, 3) == 0) ? 19'h7FFF0 + 19'($urandom_range(0, 15)) : 19'($urandom);
      a.stride = 10'($urandom);
      a.w = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 40)) : 9'($urandom_range(0, 10));
      a.h = 8'($urandom_range(0, 6));
      a.dx = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(225, 245)) : 9'($urandom);
      a.dy = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 165)) : 8'($urandom);
      a.ken = 1'($urandom);
      b = a;
      b.src = ~a.src;
      b.base = 19'($urandom);
      b.w = 9'($urandom_range(0, 8));
      b.dx = 9'($urandom_range(0, 250));
      run_cmds("random", a, b, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
